frag_write_buffer: RTL
======================

// Module: frag_write_buffer
// PURPOSE
//  Downstream of the triangle rasterizer. Accepts shaded fragments (pixel address + 24-bit RGB).
//  Buffers them in a FIFO and issues them as single-beat writes on an Avalon-MM master to the
//  frame buffer SDRAM. Decouples rasterizer throughput from memory stalls.
//  Flags the completion of each triangle once its last fragment is committed to memory.
// PARAMETERS
//  FIFO_DEPTH  16  fragment FIFO entries; power of two, >= 2
//  PIX_ADDR_W  26  width of incoming pixel (word) address
// PORTS
//  clock            in   1   system clock, all logic on posedge
//  reset            in   1   asynchronous, active-low
//  frag_valid       in   1   fragment present on frag_* inputs
//  frag_ready       out  1   buffer can accept fragment this cycle
//  frag_addr        in   26  pixel address (frame buffer base already added)
//  frag_color       in   24  RGB, {R[23:16],G[15:8],B[7:0]}
//  frag_last        in   1   fragment is the final one of the current triangle
//  avm_address      out  28  byte address = {frag_addr, 2'b00}
//  avm_write        out  1   write request
//  avm_writedata    out  32  {8'h00, color}
//  avm_byteenable   out  4   constant 4'b0111 while avm_write is high, else 4'b0000
//  avm_waitrequest  in   1   slave stall; request must be held while high
//  tri_done         out  1   one-cycle pulse: last fragment of a triangle accepted by memory
//  busy             out  1   FIFO non-empty or write outstanding
//  fifo_count       out  $clog2(FIFO_DEPTH)+1   current FIFO occupancy
// BEHAVIOUR
//  Reset: frag_ready=0 in reset, 1 on first cycle after deassertion.
//   avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0.
//   tri_done=0, busy=0, fifo_count=0; FIFO pointers cleared.
//  Entry format: {last, addr, color} = 51 bits.
//  Push: on frag_valid & frag_ready. Pop: when the output register loads.
//  frag_ready = (fifo_count != FIFO_DEPTH), combinational from the count register.
//   When full, no push occurs even if a pop happens in the same cycle.
//  Simultaneous push and pop when not full: count unchanged; both occur.
//  Pointers wrap modulo FIFO_DEPTH; count is a separate register, never exceeds DEPTH.
//  Output FSM, 2 states:
//   IDLE : avm_write=0. If FIFO non-empty, load head into output regs, pop, go to WRITE.
//   WRITE: avm_write=1; address, data and byteenable held stable while avm_waitrequest=1.
//    If avm_waitrequest=0, the write is accepted this cycle.
//     If FIFO non-empty: load next head and pop, stay in WRITE (back-to-back, 1 write/cycle).
//     Else: go to IDLE.
//  Latency: fragment accepted at edge E into empty FIFO, memory idle.
//   avm_write is high in the cycle after edge E+1 (2 cycles handshake-to-request).
//  tri_done: registered. High for exactly one cycle, in the cycle following the accepting
//   edge of a write whose entry has last=1. Back-to-back last fragments give consecutive pulses.
//  busy = (fifo_count != 0) | avm_write.
//  Color is written unmodified; no blending, no depth test, no address range check.
//  Reset mid-operation: asynchronous, immediate. An in-flight write is abandoned and
//   avm_write drops without waiting for waitrequest. Buffered fragments are discarded.
//   The memory controller is reset with the same signal.
//  frag_* inputs are sampled only on the handshake edge; their value is don't-care otherwise.
// TESTING
//  1 single fragment: addr=26'h0000100, color=24'hFF8040, last=1, waitrequest=0 ->
//    avm_write high for 1 cycle, 2 cycles after handshake.
//    avm_address=28'h0000400, avm_writedata=32'h00FF8040, byteenable=4'b0111.
//    tri_done pulses the next cycle.
//  2 stall: waitrequest=1 for 3 cycles on the first write ->
//    address/data unchanged for all 4 request cycles; exactly one write counted.
//  3 fill: waitrequest held 1, push 20 fragments with FIFO_DEPTH=16 ->
//    frag_ready=0 once count=16 (17th pending in output reg).
//    Release waitrequest -> all 17 written in order, one per cycle, no loss or duplication.
//  4 streaming: continuous valid, waitrequest=0, 100 fragments ->
//    100 writes in 101 cycles after first request, fifo_count <= 1 throughout.
//  5 triangle boundary: two triangles of 5 and 3 fragments with random waitrequest ->
//    exactly 2 tri_done pulses, each right after the 5th and 8th accepted writes.
//  6 reset mid-write: assert reset while avm_write=1 and fifo_count=6 ->
//    avm_write=0 and fifo_count=0 immediately.
//    After release, a new fragment is written correctly and no stale data appears.

Source files
------------

// File: rtl/frag_write_buffer.sv
// frag_write_buffer
// Buffers shaded fragments from the rasterizer in a FIFO and drains them as
// single-beat Avalon-MM writes to the frame buffer. It pulses tri_done once
// the last fragment of a triangle has been accepted by memory.
module frag_write_buffer #(
  parameter int FIFO_DEPTH = 16,
  parameter int PIX_ADDR_W = 26
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frag_valid,
  output logic                        frag_ready,
  input  logic [PIX_ADDR_W-1:0]       frag_addr,
  input  logic [23:0]                 frag_color,
  input  logic                        frag_last,
  output logic [PIX_ADDR_W+1:0]       avm_address,
  output logic                        avm_write,
  output logic [31:0]                 avm_writedata,
  output logic [3:0]                  avm_byteenable,
  input  logic                        avm_waitrequest,
  output logic                        tri_done,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + PIX_ADDR_W + 24;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ZERO_COUNT = {CNT_W{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  // Fragment storage and bookkeeping
  logic [ENTRY_W-1:0]    mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  ready_en_r;

  // Output side
  state_t                state_r;
  logic                  write_r;
  logic [PIX_ADDR_W+1:0] address_r;
  logic [31:0]           writedata_r;
  logic [3:0]            byteenable_r;
  logic                  last_r;
  logic                  tri_done_r;

  // Combinational helpers
  logic                  push_s;
  logic                  pop_s;
  logic                  fifo_empty_s;
  logic [ENTRY_W-1:0]    entry_in_s;
  logic [ENTRY_W-1:0]    head_s;
  logic                  head_last_s;
  logic [PIX_ADDR_W-1:0] head_addr_s;
  logic [23:0]           head_color_s;

  // Handshake, pop decision and entry packing/unpacking
  always_comb begin
    fifo_empty_s = (count_r == ZERO_COUNT);
    frag_ready   = ready_en_r & (count_r != FULL_COUNT);
    push_s       = frag_valid & frag_ready;
    entry_in_s   = {frag_last, frag_addr, frag_color};
    head_s       = mem_r[rd_ptr_r];
    head_last_s  = head_s[ENTRY_W-1];
    head_addr_s  = head_s[ENTRY_W-2 -: PIX_ADDR_W];
    head_color_s = head_s[23:0];
    pop_s        = 1'b0;
    if (fifo_empty_s) begin
      pop_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:  pop_s = 1'b1;
        ST_WRITE: pop_s = ~avm_waitrequest;
        default:  pop_s = 1'b0;
      endcase
    end
  end

  // Fragment storage array; contents are only meaningful between the pointers
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= entry_in_s;
    end
  end

  // Holds frag_ready low until the first clock edge after reset release
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally on the power-of-two depth
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= ZERO_COUNT;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Output FSM: loads the FIFO head into the write registers and holds them during stalls
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      write_r      <= 1'b0;
      address_r    <= {(PIX_ADDR_W+2){1'b0}};
      writedata_r  <= 32'h0000_0000;
      byteenable_r <= 4'b0000;
      last_r       <= 1'b0;
      tri_done_r   <= 1'b0;
    end else begin
      tri_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            address_r    <= {head_addr_s, 2'b00};
            writedata_r  <= {8'h00, head_color_s};
            byteenable_r <= 4'b0111;
            last_r       <= head_last_s;
            write_r      <= 1'b1;
            state_r      <= ST_WRITE;
          end else begin
            write_r      <= 1'b0;
            byteenable_r <= 4'b0000;
          end
        end
        ST_WRITE: begin
          if (!avm_waitrequest) begin
            tri_done_r <= last_r;
            if (!fifo_empty_s) begin
              address_r    <= {head_addr_s, 2'b00};
              writedata_r  <= {8'h00, head_color_s};
              byteenable_r <= 4'b0111;
              last_r       <= head_last_s;
              write_r      <= 1'b1;
            end else begin
              write_r      <= 1'b0;
              byteenable_r <= 4'b0000;
              state_r      <= ST_IDLE;
            end
          end else begin
            write_r <= 1'b1;
          end
        end
        default: begin
          write_r      <= 1'b0;
          byteenable_r <= 4'b0000;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign avm_address    = address_r;
  assign avm_write      = write_r;
  assign avm_writedata  = writedata_r;
  assign avm_byteenable = byteenable_r;
  assign tri_done       = tri_done_r;
  assign fifo_count     = count_r;
  assign busy           = (count_r != ZERO_COUNT) | write_r;

endmodule
